// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham line generator with start/busy and valid/ready handshakes.
// Define CLIP_EN to suppress pixels outside SCREEN_W x SCREEN_H while still stepping through them.
module line_rasterizer #(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    output logic           busy,
    output logic           pixel_valid,
    input  logic           pixel_ready,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           done
);
    localparam int W = (X_W > Y_W ? X_W : Y_W) + 2;
`ifdef CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

    state_t              state;
    logic [X_W-1:0]      lx0, lx1;
    logic [Y_W-1:0]      ly0, ly1;
    logic signed [W-1:0] dx, dy, err;
    logic                sx_neg, sy_neg, have;
    logic signed [W-1:0] adx, ady, e2, err_n;
    logic [X_W-1:0]      x_n;
    logic [Y_W-1:0]      y_n;
    logic                step_x, step_y, fire, at_end;

    function automatic logic vis(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
        return !CLIP || (int'(px) < SCREEN_W && int'(py) < SCREEN_H);
    endfunction

    always_comb begin
        adx    = lx1 >= lx0 ? W'(lx1 - lx0) : W'(lx0 - lx1);
        ady    = ly1 >= ly0 ? W'(ly1 - ly0) : W'(ly0 - ly1);
        e2     = err <<< 1;
        step_x = e2 >= dy;
        step_y = e2 <= dx;
        err_n  = err + (step_x ? dy : '0) + (step_y ? dx : '0);
        x_n    = step_x ? (sx_neg ? x - X_W'(1) : x + X_W'(1)) : x;
        y_n    = step_y ? (sy_neg ? y - Y_W'(1) : y + Y_W'(1)) : y;
        at_end = x == lx1 && y == ly1;
        // a clipped pixel is never offered, so it advances without waiting for ready
        fire   = have && (!pixel_valid || pixel_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pixel_valid <= 1'b0;
            done        <= 1'b0;
            have        <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else if (state != IDLE && abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pixel_valid <= 1'b0;
            done        <= 1'b0;
            have        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    lx0   <= x0;
                    ly0   <= y0;
                    lx1   <= x1;
                    ly1   <= y1;
                    busy  <= 1'b1;
                    state <= INIT;
                end
                INIT: begin
                    dx     <= adx;
                    dy     <= -ady;
                    err    <= adx - ady;
                    sx_neg <= lx1 < lx0;
                    sy_neg <= ly1 < ly0;
                    x      <= lx0;
                    y      <= ly0;
                    state  <= DRAW;
                end
                DRAW: if (!have) begin
                    have        <= 1'b1;
                    pixel_valid <= vis(x, y);
                end else if (fire) begin
                    if (at_end) begin
                        have        <= 1'b0;
                        pixel_valid <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        x           <= x_n;
                        y           <= y_n;
                        err         <= err_n;
                        pixel_valid <= vis(x_n, y_n);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/line_rasterizer.md
Name: line_rasterizer

Overview:
Bresenham line generator that sits between the animation/clear controller and VGA_framebuffer. It accepts one endpoint pair per start/busy handshake and emits one (x, y) pixel per accepted valid/ready beat. When the line is finished it pulses done. This replaces the free-running reset-retriggered drawer with an explicit handshake, so the controller can sequence lines and clears without timing guesses.

Parameters:
X_W, 10, x coordinate width.
Y_W, 9, y coordinate width.
SCREEN_W, 640, visible width; used only with CLIP_EN.
SCREEN_H, 480, visible height; used only with CLIP_EN.

Ports:
clk  in  1  system clock (CLOCK_50).
reset  in  1  synchronous, active-high reset.
start  in  1  request to draw; sampled only while busy=0.
abort  in  1  drop the current line immediately.
x0  in  X_W  start x; latched on an accepted start.
y0  in  Y_W  start y; latched on an accepted start.
x1  in  X_W  end x; latched on an accepted start.
y1  in  Y_W  end y; latched on an accepted start.
busy  out  1  high from the cycle after an accepted start until the return to IDLE.
pixel_valid  out  1  x and y hold a pixel to write.
pixel_ready  in  1  consumer accepts the pixel (tie to 1 for the framebuffer).
x  out  X_W  pixel x.
y  out  Y_W  pixel y.
done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset values: busy=0, pixel_valid=0, done=0, x=0, y=0; FSM in IDLE. Reset mid-line discards the line and emits no done.
- FSM states: IDLE, INIT, DRAW, DONE.
- IDLE: start=1 and abort=0 latches the endpoints and moves to INIT.
- INIT (1 cycle): compute the stepping values.
  - dx = |x1-x0|, dy = -|y1-y0|.
  - sx = +1 if x1>=x0, else -1; sy = +1 if y1>=y0, else -1.
  - err = dx+dy.
  - Load x=x0, y=y0. Move to DRAW.
- Arithmetic: err, dx, dy, and e2 are signed, max(X_W,Y_W)+2 bits wide, with no overflow over the full coordinate range.
- Latency: start accepted at edge N; pixel_valid=1 with (x0, y0) after edge N+2.
- DRAW, on a handshake (pixel_valid & pixel_ready):
  - If (x,y)==(x1,y1), go to DONE.
  - Otherwise e2 = 2*err. If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy. When both conditions hold, apply both err updates in the same cycle.
- Backpressure: while pixel_valid=1 and pixel_ready=0, x, y, and err hold. No pixel is skipped or duplicated.
- Throughput: one pixel per cycle with pixel_ready=1. A line emits exactly max(dx,|dy|)+1 pixels. Endpoints are inclusive; a degenerate line (x0==x1, y0==y1) emits 1 pixel.
- DONE (1 cycle): done=1, pixel_valid=0, busy=1. Next state is IDLE.
- start while busy=1 is ignored and not queued.
- abort in INIT, DRAW, or DONE: go to IDLE on the next edge with pixel_valid=0 and no done pulse. abort in IDLE blocks a simultaneous start.

Optional Feature:
CLIP_EN
- Defined: any pixel with x>=SCREEN_W or y>=SCREEN_H has pixel_valid forced to 0. The rasterizer still advances one step per cycle without waiting for pixel_ready, and still pulses done at the end. A line lying entirely off-screen (e.g. 641,481 to 641,481) emits no valid beats but still gives done 3 cycles after start.
- Undefined: no clipping; every computed pixel is presented. SCREEN_W and SCREEN_H are unused.

Test Plan:
- Horizontal: (0,0)->(4,0), ready=1 -> pixels x=0..4, y=0 on 5 consecutive cycles; done pulses on the cycle after (4,0); busy falls the following cycle.
- Shallow diagonal: (320,160)->(220,220) -> 101 pixels, first (320,160), last (220,220); x decrements every beat, y takes 60 steps; err never overflows.
- Vertical plus backpressure: (220,220)->(220,320), pixel_ready toggled 1,0,1,0 -> 101 distinct y values 220..320, x constant; x and y stable on every ready=0 cycle.
- Single point and ignored start: (5,5)->(5,5) -> one pixel then done; a start pulsed while busy=1 with different endpoints produces no extra pixels.
- Abort and reset: abort asserted at the 10th pixel of (0,0)->(100,50) -> pixel_valid=0 and busy=0 next cycle, no done. Repeat with reset instead of abort -> same outcome.
- CLIP_EN: (630,100)->(650,100) -> only x=630..639 presented valid; done still pulses after the x=650 step.
